bias_ramp: RTL

Slew-limited bias setpoint sequencer that sits directly upstream of the serial bias DAC interface. It accepts a target 8-bit DAC code from the host register path. It walks the DAC from its current code to the target in bounded steps. Each step issues one write strobe to the DAC serializer and waits for that frame to finish, then holds for a programmable dwell before the next step. This keeps HEMT gate bias transitions slow and monotonic.

---
 rtl/bias_ramp_pkg.sv | 20 ++
 rtl/bias_ramp_if.sv | 11 +
 rtl/bias_ramp.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/bias_ramp_pkg.sv
// Shared bias-path definitions: sequencer state encoding, default widths
// and the serial DAC frame length.
package bias_ramp_pkg;

  localparam int DAC_W_DEF     = 8;
  localparam int DWELL_W_DEF   = 16;
  localparam int ACK_TMO_DEF   = 8;
  // sp_clk cycles the serializer holds busy for one frame (/4 DAC clock)
  localparam int DAC_FRAME_LEN = 66;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CALC      = 3'd1,
    S_SEND      = 3'd2,
    S_WAIT_ACK  = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_DWELL     = 3'd5
  } state_t;

endpackage

// File: rtl/bias_ramp_if.sv
// Write handshake between the bias ramp sequencer and the DAC serializer.
interface bias_ramp_if #(
  parameter int DAC_W = 8
) ();
  logic [DAC_W-1:0] dac_data;
  logic             dac_data_val;
  logic             dac_busy;

  modport master (output dac_data, output dac_data_val, input dac_busy);
  modport slave  (input dac_data, input dac_data_val, output dac_busy);
endinterface

// File: rtl/bias_ramp.sv
// Slew-limited bias setpoint sequencer: walks the DAC toward the target in
// bounded steps, one serializer frame plus a dwell per step.
module bias_ramp
  import bias_ramp_pkg::*;
#(
  parameter int DAC_W   = DAC_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF,
  parameter int ACK_TMO = ACK_TMO_DEF
) (
  input  logic               sp_clk,
  input  logic               sp_rst,
  input  logic [DAC_W-1:0]   tgt_code,
  input  logic               tgt_val,
  input  logic [3:0]         step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               abort,
  bias_ramp_if.master        dac,
  output logic [DAC_W-1:0]   cur_code,
  output logic               ramp_busy,
  output logic               ramp_done,
  output logic               ack_err
);

  localparam int            AW       = $clog2(ACK_TMO) + 1;
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TMO - 1);

  state_t             state;
  logic [DAC_W-1:0]   tgt_q;
  logic [DAC_W-1:0]   dac_data_q;
  logic               dac_val_q;
  logic               abort_q;
  logic               abort_pend;
  logic [AW-1:0]      ack_cnt;
  logic [DWELL_W-1:0] dwell_cnt;

  assign dac.dac_data     = dac_data_q;
  assign dac.dac_data_val = dac_val_q;
  assign abort_pend       = abort_q | abort;

  // One extra bit of headroom so neither end of the code range wraps.
  function automatic logic [DAC_W-1:0] next_code(input logic [DAC_W-1:0] cur,
                                                 input logic [DAC_W-1:0] tgt,
                                                 input logic [3:0]       stp);
    logic [DAC_W:0] s, r;
    s = (stp == 4'd0) ? (DAC_W+1)'(1) : (DAC_W+1)'(stp);
    if (tgt > cur) begin
      r = {1'b0, cur} + s;
      next_code = (r > {1'b0, tgt}) ? tgt : r[DAC_W-1:0];
    end else begin
      r = {1'b0, cur} - s;
      next_code = (r[DAC_W] || (r[DAC_W-1:0] < tgt)) ? tgt : r[DAC_W-1:0];
    end
  endfunction

  always_ff @(posedge sp_clk) begin
    if (sp_rst) begin
      state      <= S_IDLE;
      tgt_q      <= '0;
      dac_data_q <= '0;
      dac_val_q  <= 1'b0;
      abort_q    <= 1'b0;
      ack_cnt    <= '0;
      dwell_cnt  <= '0;
      cur_code   <= '0;
      ramp_busy  <= 1'b0;
      ramp_done  <= 1'b0;
      ack_err    <= 1'b0;
    end else begin
      dac_val_q <= 1'b0;
      ramp_done <= 1'b0;
      if (tgt_val) tgt_q   <= tgt_code;
      if (abort)   abort_q <= 1'b1;
      // every return to IDLE below also drops ramp_busy and abort_q
      case (state)
        S_IDLE: begin
          abort_q <= 1'b0;
          if (tgt_val && !abort) begin
            if (tgt_code != cur_code) begin
              state     <= S_CALC;
              ramp_busy <= 1'b1;
            end else begin
              ramp_done <= 1'b1;
            end
          end
        end
        S_CALC: begin
          if (abort_pend) begin
            state <= S_IDLE; ramp_busy <= 1'b0; abort_q <= 1'b0;
          end else if (tgt_q == cur_code) begin
            // a retarget onto the current code needs no frame
            ramp_done <= 1'b1;
            state <= S_IDLE; ramp_busy <= 1'b0; abort_q <= 1'b0;
          end else begin
            dac_data_q <= next_code(cur_code, tgt_q, step);
            dac_val_q  <= 1'b1;
            ack_cnt    <= '0;
            state      <= S_SEND;
          end
        end
        S_SEND: begin
          ack_cnt <= ack_cnt + AW'(1);
          state   <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (dac.dac_busy) begin
            state <= S_WAIT_DONE;
          end else if (ack_cnt == ACK_LAST) begin
            ack_err <= 1'b1;
            state <= S_IDLE; ramp_busy <= 1'b0; abort_q <= 1'b0;
          end else begin
            ack_cnt <= ack_cnt + AW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!dac.dac_busy) begin
            cur_code <= dac_data_q;
            if (dac_data_q == tgt_q) begin
              ramp_done <= 1'b1;
              state <= S_IDLE; ramp_busy <= 1'b0; abort_q <= 1'b0;
            end else if (abort_pend) begin
              state <= S_IDLE; ramp_busy <= 1'b0; abort_q <= 1'b0;
            end else begin
              dwell_cnt <= '0;
              state     <= S_DWELL;
            end
          end
        end
        S_DWELL: begin
          if (abort_pend) begin
            state <= S_IDLE; ramp_busy <= 1'b0; abort_q <= 1'b0;
          end else if ((dwell_cnt + DWELL_W'(1)) >= dwell) begin
            state <= S_CALC;
          end else begin
            dwell_cnt <= dwell_cnt + DWELL_W'(1);
          end
        end
        default: begin
          state <= S_IDLE; ramp_busy <= 1'b0; abort_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
